// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite widths, response codes and payload types.
// Used by axi_lite_master, its bus interface and the bench.
package axi_lite_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [1:0]            resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels).
// master modport drives requests, slave modport drives readies/responses.
interface axi_lite_master_if
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = axi_lite_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_lite_pkg::DATA_WIDTH
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  resp_t                 BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  resp_t                 RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID,
    output BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID,
    input  BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID,
    output ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi_lite_master.sv
// AXI4-Lite master, one outstanding command, registered response.
// Define AXI_LITE_MASTER_TIMEOUT_EN for the sticky watchdog flag.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = axi_lite_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = axi_lite_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output resp_t                 rsp_resp,
  axi_lite_master_if.master     m_axi,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    IDLE, WREQ, WRESP, RREQ, RDATA, RSP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_rsp_write;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  resp_t                 r_rsp_resp;
  logic                  w_aw_fire;
  logic                  w_w_fire;

  assign w_aw_fire = m_axi.AWVALID & m_axi.AWREADY;
  assign w_w_fire  = m_axi.WVALID & m_axi.WREADY;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (cmd_valid)
               w_next = cmd_write ? WREQ : RREQ;
      WREQ:  if ((r_aw_done | w_aw_fire) &&
                 (r_w_done | w_w_fire))
               w_next = WRESP;
      WRESP: if (m_axi.BVALID) w_next = RSP;
      RREQ:  if (m_axi.ARREADY) w_next = RDATA;
      RDATA: if (m_axi.RVALID) w_next = RSP;
      RSP:   if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && cmd_valid) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      // each channel remembers its own handshake
      if (r_state == WREQ) begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire)  r_w_done  <= 1'b1;
      end
      if (r_state == WRESP && m_axi.BVALID) begin
        r_rsp_write <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m_axi.BRESP;
      end
      if (r_state == RDATA && m_axi.RVALID) begin
        r_rsp_write <= 1'b0;
        r_rsp_rdata <= m_axi.RDATA;
        r_rsp_resp  <= m_axi.RRESP;
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RSP);
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

  assign m_axi.AWADDR  = r_addr;
  assign m_axi.AWVALID = (r_state == WREQ) & ~r_aw_done;
  assign m_axi.WDATA   = r_wdata;
  assign m_axi.WSTRB   = r_wstrb;
  assign m_axi.WVALID  = (r_state == WREQ) & ~r_w_done;
  assign m_axi.BREADY  = (r_state == WRESP);
  assign m_axi.ARADDR  = r_addr;
  assign m_axi.ARVALID = (r_state == RREQ);
  assign m_axi.RREADY  = (r_state == RDATA);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_tmo;
  logic          w_wait;
  logic          w_stay;

  assign w_wait = r_state inside {WREQ, WRESP, RREQ, RDATA};
  assign w_stay = w_wait & (w_next == r_state);

  // flag only; the FSM keeps waiting for the slave
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      if (!w_stay)
        r_cnt <= '0;
      else if (r_cnt != CW'(TIMEOUT_CYCLES))
        r_cnt <= r_cnt + 1'b1;
      if (w_stay && r_cnt == CW'(TIMEOUT_CYCLES - 1))
        r_tmo <= 1'b1;
    end
  end

  assign timeout_err = r_tmo;
`else
  assign timeout_err = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 32, AXI address width (axi_lite_pkg::ADDR_WIDTH).
REQ-002 SHALL have parameter: DATA_WIDTH, 32, AXI data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter: TIMEOUT_CYCLES, 256, watchdog limit (used only with AXI_LITE_MASTER_TIMEOUT_EN).
REQ-004 SHALL have the following ports, one per line (name  direction  width  meaning):
  ACLK  in  1  clock, rising edge
  ARESETN  in  1  reset, asynchronous assert, active-low
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  ADDR_WIDTH  target address
  cmd_wdata  in  DATA_WIDTH  write data
  cmd_wstrb  in  STRB_WIDTH  write strobes
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed
  rsp_write  out  1  response belongs to a write
  rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
  rsp_resp  out  2  BRESP/RRESP value
  AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out -- standard AXI4-Lite master widths
  timeout_err  out  1  sticky watchdog flag (tied 0 without macro)

Function
REQ-005 SHALL implement FSM states IDLE, WREQ, WRESP, RREQ, RDATA, RSP; one outstanding transaction only.
REQ-006 SHALL drive cmd_ready=1 only in IDLE; cmd_valid&cmd_ready captures addr/data/strb/write into registers.
REQ-007 SHALL go IDLE->WREQ on accepted write, IDLE->RREQ on accepted read; AXI valids rise the cycle after acceptance.
REQ-008 In WREQ SHALL assert AWVALID and WVALID together; each drops the cycle after its own handshake; payload stable while valid.
REQ-009 SHALL leave WREQ for WRESP once both AW and W handshakes are done, including both in the same cycle or W before AW.
REQ-010 SHALL assert BREADY only in WRESP; on BVALID capture BRESP, rsp_write=1, rsp_rdata=0, go RSP.
REQ-011 SHALL assert ARVALID only in RREQ; on ARREADY go RDATA; RREADY only in RDATA; on RVALID capture RDATA/RRESP, rsp_write=0, go RSP.
REQ-012 SHALL hold rsp_valid=1 and response fields stable in RSP until rsp_ready, then return to IDLE; minimum command-to-rsp_valid latency 3 cycles with zero-wait slave.
REQ-013 SHALL never deassert an AXI valid before its ready (no abort), regardless of timeout.
REQ-014 SHALL forward any non-OKAY response (SLVERR, DECERR) unchanged on rsp_resp.
REQ-015 All AXI and rsp outputs SHALL be registered or decoded directly from state (no input-to-output combinational path).

Reset
REQ-016 On ARESETN low, asynchronously: state=IDLE, all VALID/READY outputs 0 except cmd_ready=1 after release, addresses/data/rsp fields 0, timeout_err 0.
REQ-017 Reset mid-transaction SHALL abandon it with no response generated.

Configuration
REQ-018 With AXI_LITE_MASTER_TIMEOUT_EN defined: counter resets on each state change, increments in WREQ/WRESP/RREQ/RDATA; reaching TIMEOUT_CYCLES sets timeout_err (sticky until reset); FSM continues waiting.
REQ-019 Without AXI_LITE_MASTER_TIMEOUT_EN: no counter instantiated, timeout_err tied 0.

Structure
REQ-020 Widths, RESP_* constants, addr_t/data_t/strb_t/resp_t SHALL come from axi_lite_pkg; FSM state enum local to the module.
REQ-021 SHALL be a single module; no sub-module.

Verification
REQ-022 Write 0x10<-0xDEADBEEF, strb 0xF, slave readies same cycle -> AWADDR=0x10, WDATA=0xDEADBEEF, rsp_valid with rsp_resp=00, rsp_write=1.
REQ-023 Read 0x10 after REQ-022 against a memory slave -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_write=0.
REQ-024 Write where slave gives WREADY 3 cycles before AWREADY -> WVALID drops after W handshake, AWVALID held, single BREADY phase, one response.
REQ-025 Slave returns RRESP=10 -> rsp_resp=10; rsp_ready held low 5 cycles -> rsp fields stable, cmd_ready=0 throughout.
REQ-026 Macro defined, TIMEOUT_CYCLES=8, ARREADY never asserted -> timeout_err=1 at count 8, ARVALID stays 1; ARESETN pulse mid-transfer -> all valids 0, timeout_err 0, cmd_ready 1.
